// File: rtl/rv32i_pkg.sv
// Shared RV32I machine-mode CSR types: op/state encodings, write-enable enum and CSR addresses.
package rv32i;

  typedef enum logic {
    REG_WE_N = 1'b0,
    REG_WE   = 1'b1
  } reg_we_e;

  // funct3-style encoding; ECALL and MRET occupy the two slots Zicsr leaves free
  typedef enum logic [2:0] {
    ECALL  = 3'd0,
    CSRRW  = 3'd1,
    CSRRS  = 3'd2,
    CSRRC  = 3'd3,
    MRET   = 3'd4,
    CSRRWI = 3'd5,
    CSRRSI = 3'd6,
    CSRRCI = 3'd7
  } csr_op_e;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ACCESS     = 3'd1,
    S_TRAP_EPC   = 3'd2,
    S_TRAP_CAUSE = 3'd3,
    S_TRAP_VEC   = 3'd4,
    S_RET        = 3'd5,
    S_DONE       = 3'd6
  } csr_exec_state_e;

  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;
  localparam logic [11:0] CSR_CYCLE   = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH  = 12'hC80;
  localparam logic [31:0] CAUSE_ECALL_M = 32'hb;

endpackage

// File: rtl/csr_exec_unit_rmw_alu.sv
// Zicsr read-modify-write datapath: new value and write enable from op, old value and source.
module csr_rmw_alu import rv32i::*; (
  input  csr_op_e     op_i,
  input  logic [31:0] old_i,
  input  logic [31:0] src_i,
  input  logic        src_x0_i,
  output logic [31:0] new_o,
  output logic        we_o
);

  // Set/clear with an x0 source is a pure read; unknown ops fall back to that too
  always_comb begin
    new_o = old_i;
    we_o  = 1'b0;
    case (op_i)
      CSRRW, CSRRWI: begin new_o = src_i;          we_o = 1'b1;      end
      CSRRS, CSRRSI: begin new_o = old_i | src_i;  we_o = !src_x0_i; end
      CSRRC, CSRRCI: begin new_o = old_i & ~src_i; we_o = !src_x0_i; end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_exec_unit.sv
// CSR sequencer: drives the single-port CSR file for Zicsr ops, ECALL trap entry and MRET.
// Optional feature macro: CSR_EXEC_CYCLE_COUNTER_EN (internal 64-bit mcycle/cycle counter).
module csr_exec_unit import rv32i::*; #(
  parameter logic [11:0] MTVEC_ADDR  = CSR_MTVEC,
  parameter logic [11:0] MEPC_ADDR   = CSR_MEPC,
  parameter logic [11:0] MCAUSE_ADDR = CSR_MCAUSE,
  parameter logic [31:0] ECALL_CAUSE = CAUSE_ECALL_M
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  csr_op_e     req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_src,
  input  logic        req_src_x0,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output reg_we_e     csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata
);

  csr_exec_state_e state_q, state_d;
  csr_op_e         op_q;
  logic [11:0]     addr_q;
  logic [31:0]     src_q, pc_q;
  logic            x0_q;
  logic [31:0]     rdata_q, rdata_d, target_q, target_d;
  logic [11:0]     addr_hold_q;
  logic [31:0]     wdata_hold_q;
  logic [31:0]     old_val, alu_new;
  logic            alu_we, cnt_hit;

  csr_rmw_alu u_alu (
    .op_i     (op_q),
    .old_i    (old_val),
    .src_i    (src_q),
    .src_x0_i (x0_q),
    .new_o    (alu_new),
    .we_o     (alu_we)
  );

`ifdef CSR_EXEC_CYCLE_COUNTER_EN
  logic [63:0] mcycle_q, mcycle_d;

  // Counter CSRs are served locally and never reach the file
  always_comb begin
    cnt_hit = (addr_q == CSR_MCYCLE) || (addr_q == CSR_MCYCLEH) ||
              (addr_q == CSR_CYCLE)  || (addr_q == CSR_CYCLEH);
    old_val = csr_rdata;
    if (addr_q == CSR_MCYCLE || addr_q == CSR_CYCLE)        old_val = mcycle_q[31:0];
    else if (addr_q == CSR_MCYCLEH || addr_q == CSR_CYCLEH) old_val = mcycle_q[63:32];
    mcycle_d = mcycle_q + 64'd1;
    if (state_q == S_ACCESS && alu_we) begin
      if (addr_q == CSR_MCYCLE)       mcycle_d = {mcycle_q[63:32], alu_new};
      else if (addr_q == CSR_MCYCLEH) mcycle_d = {alu_new, mcycle_q[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mcycle_q <= '0;
    else     mcycle_q <= mcycle_d;
  end
`else
  assign cnt_hit = 1'b0;
  assign old_val = csr_rdata;
`endif

  // Address/data fall back to the held copies so the port only moves when driven
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    target_d  = target_q;
    csr_addr  = addr_hold_q;
    csr_wdata = wdata_hold_q;
    csr_we    = REG_WE_N;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            ECALL:   state_d = S_TRAP_EPC;
            MRET:    state_d = S_RET;
            default: state_d = S_ACCESS;
          endcase
        end
      end
      S_ACCESS: begin
        csr_addr = addr_q;
        rdata_d  = old_val;
        if (alu_we && !cnt_hit) begin
          csr_we    = REG_WE;
          csr_wdata = alu_new;
        end
        state_d = S_DONE;
      end
      S_TRAP_EPC: begin
        csr_addr  = MEPC_ADDR;
        csr_wdata = pc_q & ~32'h3;
        csr_we    = REG_WE;
        state_d   = S_TRAP_CAUSE;
      end
      S_TRAP_CAUSE: begin
        csr_addr  = MCAUSE_ADDR;
        csr_wdata = ECALL_CAUSE;
        csr_we    = REG_WE;
        state_d   = S_TRAP_VEC;
      end
      S_TRAP_VEC: begin
        csr_addr = MTVEC_ADDR;
        target_d = csr_rdata & ~32'h3;
        rdata_d  = '0;
        state_d  = S_DONE;
      end
      S_RET: begin
        csr_addr = MEPC_ADDR;
        target_d = csr_rdata & ~32'h3;
        rdata_d  = '0;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= CSRRS;
      addr_q       <= '0;
      src_q        <= '0;
      x0_q         <= 1'b1;
      pc_q         <= '0;
      rdata_q      <= '0;
      target_q     <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      target_q     <= target_d;
      addr_hold_q  <= csr_addr;
      wdata_hold_q <= csr_wdata;
      if (state_q == S_IDLE && req_valid) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        src_q  <= req_src;
        x0_q   <= req_src_x0;
        pc_q   <= req_pc;
      end
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign resp_valid     = (state_q == S_DONE);
  assign redirect_valid = (state_q == S_DONE) && (op_q == ECALL || op_q == MRET);
  assign resp_rdata     = rdata_q;
  assign redirect_pc    = target_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Randomized self-checking bench for csr_exec_unit with a behavioural CSR-file model.
module tb_csr_exec_unit;
  import rv32i::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  csr_op_e     req_op = CSRRS;
  logic [11:0] req_addr = '0;
  logic [31:0] req_src = '0;
  logic        req_src_x0 = 1'b0;
  logic [31:0] req_pc = '0;
  logic        resp_valid, redirect_valid;
  logic [31:0] resp_rdata, redirect_pc;
  reg_we_e     csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;

  csr_exec_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_src(req_src), .req_src_x0(req_src_x0),
    .req_pc(req_pc), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wcount = 0;
  logic [31:0] env_file [0:4095];  // the CSR file the DUT talks to
  logic [31:0] mdl [0:4095];       // what the file should contain

  assign csr_rdata = env_file[csr_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (csr_we == REG_WE) begin
      env_file[csr_addr] <= csr_wdata;
      wcount <= wcount + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected schedule of the op in flight
  int acc_cyc = -100;
  int done_cyc = -100;
  logic [31:0] e_rd = '0, e_pc = '0;
  bit e_redir = 1'b0, e_chkrd = 1'b0, cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, !(cyc >= acc_cyc && cyc <= done_cyc)});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, cyc == done_cyc});
      chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, (cyc == done_cyc) && e_redir});
      if (cyc == done_cyc) begin
        if (e_chkrd) chk("resp_rdata", resp_rdata, e_rd);
        if (e_redir) chk("redirect_pc", redirect_pc, e_pc);
      end
    end
  end

  task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
    env_file[a] <= v;
    mdl[a] = v;
  endtask

  task automatic do_op(input csr_op_e op, input logic [11:0] a, input logic [31:0] src,
                       input logic x0, input logic [31:0] pc, input bit chkrd);
    int L, nw, w0;
    logic [31:0] old;
    @(negedge clk); #2;
    e_chkrd = chkrd; e_redir = 1'b0; e_rd = '0; nw = 0; L = 2;
    case (op)
      ECALL: begin
        mdl[CSR_MEPC] = pc & ~32'h3;
        mdl[CSR_MCAUSE] = 32'hb;
        e_pc = mdl[CSR_MTVEC] & ~32'h3;
        e_redir = 1'b1; L = 4; nw = 2;
      end
      MRET: begin
        e_pc = mdl[CSR_MEPC] & ~32'h3;
        e_redir = 1'b1;
      end
      default: begin
        old = mdl[a];
        e_rd = old;
        if (op == CSRRW || op == CSRRWI) begin
          mdl[a] = src; nw = 1;
        end else if (!x0) begin
          nw = 1;
          mdl[a] = (op == CSRRS || op == CSRRSI) ? (old | src) : (old & ~src);
        end
      end
    endcase
    acc_cyc = cyc + 1;
    done_cyc = cyc + L;
    w0 = wcount;
    req_valid = 1'b1; req_op = op; req_addr = a; req_src = src; req_src_x0 = x0; req_pc = pc;
    @(posedge clk); #1;
    // scramble fields after accept: the DUT must have latched them
    req_valid = 1'b0;
    req_op = csr_op_e'(3'($urandom_range(0, 7)));
    req_addr = 12'($urandom); req_src = $urandom; req_pc = $urandom; req_src_x0 = 1'($urandom);
    repeat (L) @(negedge clk);
    #2;
    chk("write_count", 32'(wcount - w0), 32'(nw));
    if (op == ECALL) begin
      chk("mepc", env_file[CSR_MEPC], mdl[CSR_MEPC]);
      chk("mcause", env_file[CSR_MCAUSE], mdl[CSR_MCAUSE]);
    end else if (op != MRET) begin
      chk("file_data", env_file[a], mdl[a]);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_csr_addr", {20'b0, csr_addr}, 32'd0);
    chk("rst_csr_wdata", csr_wdata, 32'd0);
    chk("rst_csr_we", {31'b0, csr_we == REG_WE}, 32'd0);
  endtask

  logic [11:0] addrs [0:5];
  csr_op_e     zops  [0:5];

  initial begin
    addrs[0] = 12'h300; addrs[1] = 12'h301; addrs[2] = 12'h340;
    addrs[3] = CSR_MTVEC; addrs[4] = CSR_MEPC; addrs[5] = CSR_MCAUSE;
    zops[0] = CSRRW; zops[1] = CSRRS; zops[2] = CSRRC;
    zops[3] = CSRRWI; zops[4] = CSRRSI; zops[5] = CSRRCI;
    for (int i = 0; i < 4096; i++) begin
      env_file[i] <= '0;
      mdl[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    cmp_en = 1'b1;

    // directed cases with hand-computed results
    set_csr(12'h300, 32'hAA);
    do_op(CSRRW, 12'h300, 32'h1234, 1'b0, 32'h0, 1'b1);
    chk("lit_rw_rdata", resp_rdata, 32'hAA);
    chk("lit_rw_file", env_file[12'h300], 32'h1234);

    set_csr(12'h300, 32'h00F);
    do_op(CSRRS, 12'h300, 32'h0F0, 1'b0, 32'h0, 1'b1);
    chk("lit_rs_file", env_file[12'h300], 32'h0FF);

    do_op(CSRRS, 12'h300, 32'h0, 1'b1, 32'h0, 1'b1);
    chk("lit_rs_x0_file", env_file[12'h300], 32'h0FF);

    do_op(CSRRCI, 12'h300, 32'h3, 1'b0, 32'h0, 1'b1);
    chk("lit_rci_file", env_file[12'h300], 32'hFC);

    set_csr(CSR_MTVEC, 32'h100);
    do_op(ECALL, 12'h000, 32'h0, 1'b0, 32'h8000_0044, 1'b1);
    chk("lit_ecall_mepc", env_file[CSR_MEPC], 32'h8000_0044);
    chk("lit_ecall_mcause", env_file[CSR_MCAUSE], 32'hb);
    chk("lit_ecall_target", redirect_pc, 32'h100);

    set_csr(CSR_MEPC, 32'h8000_0048);
    do_op(MRET, 12'h000, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("lit_mret_target", redirect_pc, 32'h8000_0048);

    // reset landing in TRAP_CAUSE
    cmp_en = 1'b0;
    @(negedge clk); #2;
    req_valid = 1'b1; req_op = ECALL; req_pc = 32'h0000_1003;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    chk("rst_mid_mepc", env_file[CSR_MEPC], 32'h0000_1000);
    #2;
    mdl[CSR_MEPC] = 32'h0000_1000;
    set_csr(CSR_MCAUSE, 32'h0);
    acc_cyc = -100; done_cyc = -100;
    cmp_en = 1'b1;

    for (int n = 0; n < 300; n++) begin
      int k;
      csr_op_e op;
      logic [11:0] a;
      logic x0;
      logic [31:0] s;
      k = $urandom_range(0, 9);
      if (k == 6) op = ECALL;
      else if (k == 7) op = MRET;
      else op = zops[$urandom_range(0, 5)];
      a = addrs[$urandom_range(0, 5)];
      x0 = ($urandom_range(0, 3) == 0);
      if (x0) s = '0;
      else if (op == CSRRWI || op == CSRRSI || op == CSRRCI) s = 32'($urandom_range(1, 31));
      else s = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(op, a, s, x0, $urandom, 1'b1);
    end

`ifdef CSR_EXEC_CYCLE_COUNTER_EN
    begin
      logic [31:0] c0;
      do_op(CSRRS, CSR_MCYCLE, 32'h0, 1'b1, 32'h0, 1'b0);
      c0 = resp_rdata;
      repeat (5) @(negedge clk);
      do_op(CSRRS, CSR_MCYCLE, 32'h0, 1'b1, 32'h0, 1'b0);
      chk("mcycle_delta", resp_rdata - c0, 32'd8);
    end
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
